// File: rtl/syscall_unit.sv
// syscall_unit: executes SPIM-style system calls selected by $v0 when the decode
// stage flags a syscall. Supported codes: 1 print int, 4 print string, 10 exit,
// 11 print char. The pipeline is frozen with stall while a call is in progress.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   syscall_control       syscall instruction present in ID
//   v0, a0                call code and argument/pointer from the register file
//   mem_req/mem_addr      word-aligned data-memory read request, held until mem_ready
//   mem_ready/mem_rdata   read completion and big-endian read data
//   stall                 freeze PC and IF/ID
//   char_valid/char_data  one-cycle character strobe to the console
//   int_valid/int_data    one-cycle signed integer strobe to the console
//   halt                  sticky, program exited
//   bad_code              one-cycle strobe, unsupported $v0
//   str_trunc             one-cycle strobe, string cut at MAX_STR_LEN characters
module syscall_unit #(
  parameter int unsigned MAX_STR_LEN = 256,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              syscall_control,
  input  logic [31:0]       v0,
  input  logic [ADDR_W-1:0] a0,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              stall,
  output logic              char_valid,
  output logic [7:0]        char_data,
  output logic              int_valid,
  output logic [31:0]       int_data,
  output logic              halt,
  output logic              bad_code,
  output logic              str_trunc
);

  localparam int unsigned CntW = $clog2(MAX_STR_LEN + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_STR_LEN);

  localparam logic [31:0] CodePrintInt  = 32'd1;
  localparam logic [31:0] CodePrintStr  = 32'd4;
  localparam logic [31:0] CodeExit      = 32'd10;
  localparam logic [31:0] CodePrintChar = 32'd11;

  typedef enum logic [2:0] {
    StIdle,
    StDispatch,
    StStrReq,
    StStrEmit,
    StDone,
    StHalted
  } state_e;

  state_e state_q, state_d;

  // ptr_q also serves as the captured argument: it is loaded from a0 on acceptance.
  logic [31:0]       code_q, code_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [7:0]        byte_q, byte_d;

  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              char_valid_q, char_valid_d;
  logic [7:0]        char_data_q, char_data_d;
  logic              int_valid_q, int_valid_d;
  logic [31:0]       int_data_q, int_data_d;
  logic              halt_q, halt_d;
  logic              bad_code_q, bad_code_d;
  logic              str_trunc_q, str_trunc_d;

  logic [7:0] byte_sel;

  // Big-endian byte lane selected by the low pointer bits.
  always_comb begin
    byte_sel = mem_rdata[31:24];
    case (ptr_q[1:0])
      2'd0:    byte_sel = mem_rdata[31:24];
      2'd1:    byte_sel = mem_rdata[23:16];
      2'd2:    byte_sel = mem_rdata[15:8];
      default: byte_sel = mem_rdata[7:0];
    endcase
  end

  // Strobes are registered, so they are computed on the transition into the state
  // in which they are visible (DISPATCH for int/char/bad/halt, STR_EMIT for chars).
  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    byte_d       = byte_q;
    char_valid_d = 1'b0;
    char_data_d  = char_data_q;
    int_valid_d  = 1'b0;
    int_data_d   = int_data_q;
    halt_d       = halt_q;
    bad_code_d   = 1'b0;
    str_trunc_d  = 1'b0;
    mem_req_d    = 1'b0;
    mem_addr_d   = mem_addr_q;

    unique case (state_q)
      StIdle: begin
        if (syscall_control) begin
          state_d = StDispatch;
          code_d  = v0;
          ptr_d   = a0;
          cnt_d   = '0;
          case (v0)
            CodePrintInt: begin
              int_valid_d = 1'b1;
              int_data_d  = 32'(a0);
            end
            CodePrintChar: begin
              char_valid_d = 1'b1;
              char_data_d  = a0[7:0];
            end
            CodePrintStr: ;
            CodeExit:     halt_d = 1'b1;
            default:      bad_code_d = 1'b1;
          endcase
        end
      end

      StDispatch: begin
        case (code_q)
          CodePrintStr: state_d = StStrReq;
          CodeExit:     state_d = StHalted;
          default:      state_d = StDone;
        endcase
      end

      StStrReq: begin
        if (mem_ready) begin
          byte_d  = byte_sel;
          state_d = StStrEmit;
          if (byte_sel != 8'h00) begin
            char_valid_d = 1'b1;
            char_data_d  = byte_sel;
            str_trunc_d  = (cnt_q + CntW'(1)) == CntMax;
          end
        end
      end

      StStrEmit: begin
        if (byte_q == 8'h00) begin
          state_d = StDone;
        end else begin
          ptr_d   = ptr_q + ADDR_W'(1);
          cnt_d   = cnt_q + CntW'(1);
          state_d = (cnt_d == CntMax) ? StDone : StStrReq;
        end
      end

      StDone:   state_d = StIdle;
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase

    // Request is a registered copy of "next state is STR_REQ", so it holds
    // steady through wait states and drops in STR_EMIT.
    if (state_d == StStrReq) begin
      mem_req_d  = 1'b1;
      mem_addr_d = {ptr_d[ADDR_W-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      code_q       <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      byte_q       <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      char_valid_q <= 1'b0;
      char_data_q  <= '0;
      int_valid_q  <= 1'b0;
      int_data_q   <= '0;
      halt_q       <= 1'b0;
      bad_code_q   <= 1'b0;
      str_trunc_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      byte_q       <= byte_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      char_valid_q <= char_valid_d;
      char_data_q  <= char_data_d;
      int_valid_q  <= int_valid_d;
      int_data_q   <= int_data_d;
      halt_q       <= halt_d;
      bad_code_q   <= bad_code_d;
      str_trunc_q  <= str_trunc_d;
    end
  end

  // Stall asserts in the acceptance cycle itself so IF/ID never moves past the syscall.
  always_comb begin
    stall = 1'b0;
    unique case (state_q)
      StIdle:     stall = syscall_control;
      StDispatch: stall = 1'b1;
      StStrReq:   stall = 1'b1;
      StStrEmit:  stall = 1'b1;
      StHalted:   stall = 1'b1;
      default:    stall = 1'b0;
    endcase
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign char_valid = char_valid_q;
  assign char_data  = char_data_q;
  assign int_valid  = int_valid_q;
  assign int_data   = int_data_q;
  assign halt       = halt_q;
  assign bad_code   = bad_code_q;
  assign str_trunc  = str_trunc_q;

endmodule

// File: tb/tb_syscall_unit.sv
// Self-checking bench for syscall_unit (instantiated with MAX_STR_LEN=4 so the
// truncation limit is reachable with short strings).
module tb_syscall_unit;

  localparam int unsigned MaxLen = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        syscall_control = 1'b0;
  logic [31:0] v0 = '0;
  logic [31:0] a0 = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        int_valid;
  logic [31:0] int_data;
  logic        halt;
  logic        bad_code;
  logic        str_trunc;

  always #5 clk = ~clk;

  syscall_unit #(
    .MAX_STR_LEN(MaxLen),
    .ADDR_W     (32)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .syscall_control(syscall_control),
    .v0             (v0),
    .a0             (a0),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ready      (mem_ready),
    .mem_rdata      (mem_rdata),
    .stall          (stall),
    .char_valid     (char_valid),
    .char_data      (char_data),
    .int_valid      (int_valid),
    .int_data       (int_data),
    .halt           (halt),
    .bad_code       (bad_code),
    .str_trunc      (str_trunc)
  );

  // Memory model: ready comes after mem_wait cycles of a held request.
  logic [31:0] mem [0:255];
  int          mem_wait = 0;
  int          wcnt = 0;

  assign mem_rdata = mem[mem_addr[9:2]];
  assign mem_ready = mem_req && (wcnt == mem_wait);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) wcnt <= 0;
    else if (!mem_req || mem_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] v0;
    logic [31:0] a0;
    logic        exp_int;
    logic [31:0] exp_int_data;
    logic        exp_char;
    logic [7:0]  exp_char_data;
    logic        exp_bad;
  } vec_t;

  vec_t vecs [7];

  // Single-cycle call: accept, check DISPATCH strobes, DONE releases stall, back to IDLE.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    syscall_control = 1'b1;
    v0 = v.v0;
    a0 = v.a0;
    #1;
    check({v.name, "_stall_accept"}, 32'(stall), 32'd1);
    @(negedge clk);
    check({v.name, "_int_valid"}, 32'(int_valid), 32'(v.exp_int));
    if (v.exp_int) check({v.name, "_int_data"}, int_data, v.exp_int_data);
    check({v.name, "_char_valid"}, 32'(char_valid), 32'(v.exp_char));
    if (v.exp_char) check({v.name, "_char_data"}, 32'(char_data), 32'(v.exp_char_data));
    check({v.name, "_bad_code"}, 32'(bad_code), 32'(v.exp_bad));
    check({v.name, "_trunc_halt"}, 32'({str_trunc, halt}), 32'd0);
    check({v.name, "_stall_dispatch"}, 32'(stall), 32'd1);
    // Argument changes after capture must not matter.
    v0 = 32'hFFFF_FFFF;
    a0 = ~v.a0;
    @(negedge clk);
    check({v.name, "_stall_done"}, 32'(stall), 32'd0);
    check({v.name, "_strobes_done"}, 32'({int_valid, char_valid, bad_code}), 32'd0);
    @(negedge clk);
    syscall_control = 1'b0;
    #1;
    check({v.name, "_stall_idle"}, 32'(stall), 32'd0);
  endtask

  // String call monitor results.
  logic [7:0]  got [16];
  int          got_at [16];
  int          n_got, trunc_cnt, trunc_cyc, hold_err, align_err, extra, n_hs, end_cyc;
  logic [31:0] hs_addr [16];
  logic        timed_out;

  task automatic run_str(input logic [31:0] addr, input int wait_c);
    logic        prev_wait;
    logic [31:0] prev_addr;
    logic        done;
    n_got = 0; trunc_cnt = 0; trunc_cyc = -1; hold_err = 0; align_err = 0;
    extra = 0; n_hs = 0; end_cyc = -1; timed_out = 1'b0;
    prev_wait = 1'b0; prev_addr = '0; done = 1'b0;
    mem_wait = wait_c;
    @(negedge clk);
    syscall_control = 1'b1;
    v0 = 32'd4;
    a0 = addr;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (char_valid && n_got < 16) begin
        got[n_got] = char_data;
        got_at[n_got] = c;
        n_got++;
      end
      if (str_trunc) begin
        trunc_cnt++;
        trunc_cyc = c;
      end
      if (int_valid || bad_code || halt) extra++;
      if (mem_req && mem_addr[1:0] != 2'b00) align_err++;
      if (prev_wait && (!mem_req || mem_addr != prev_addr)) hold_err++;
      if (mem_req && mem_ready && n_hs < 16) begin
        hs_addr[n_hs] = mem_addr;
        n_hs++;
      end
      prev_wait = mem_req && !mem_ready;
      prev_addr = mem_addr;
      if (!stall) begin
        end_cyc = c;
        done = 1'b1;
        break;
      end
    end
    if (!done) timed_out = 1'b1;
    syscall_control = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_str(input string name, input string exp, input int exp_trunc,
                           input int exp_hs, input logic [31:0] exp_hs_addr_last,
                           input int exp_end);
    check({name, "_timeout"}, 32'(timed_out), 32'd0);
    check({name, "_nchars"}, 32'(n_got), 32'(exp.len()));
    for (int i = 0; i < exp.len() && i < n_got; i++)
      check({name, "_char"}, 32'(got[i]), 32'(exp[i]));
    check({name, "_trunc_cnt"}, 32'(trunc_cnt), 32'(exp_trunc));
    if (exp_trunc > 0 && n_got > 0)
      check({name, "_trunc_cycle"}, 32'(trunc_cyc), 32'(got_at[n_got-1]));
    check({name, "_hold"}, 32'(hold_err), 32'd0);
    check({name, "_align"}, 32'(align_err), 32'd0);
    check({name, "_extra_strobes"}, 32'(extra), 32'd0);
    check({name, "_n_req"}, 32'(n_hs), 32'(exp_hs));
    if (n_hs > 0) check({name, "_last_addr"}, hs_addr[n_hs-1], exp_hs_addr_last);
    check({name, "_end_cycle"}, 32'(end_cyc), 32'(exp_end));
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h40] = 32'h4869_0000;  // 0x100 "Hi\0"
    mem[8'h80] = 32'h4142_4344;  // 0x200 "ABCD"
    mem[8'h81] = 32'h4546_0000;  // 0x204 "EF\0"
    mem[8'hC0] = 32'h7879_7A00;  // 0x300 "xyz\0"

    vecs[0] = '{"int_neg7",   32'd1,  32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF9, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{"int_max",    32'd1,  32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{"char_A",     32'd11, 32'h0000_0041, 1'b0, 32'h0,         1'b1, 8'h41, 1'b0};
    vecs[3] = '{"char_low",   32'd11, 32'h1234_5663, 1'b0, 32'h0,         1'b1, 8'h63, 1'b0};
    vecs[4] = '{"bad_99",     32'd99, 32'h0000_0041, 1'b0, 32'h0,         1'b0, 8'h00, 1'b1};
    vecs[5] = '{"bad_0",      32'd0,  32'h0000_0001, 1'b0, 32'h0,         1'b0, 8'h00, 1'b1};
    vecs[6] = '{"bad_hi",     32'h101, 32'h0000_0007, 1'b0, 32'h0,        1'b0, 8'h00, 1'b1};

    #1 reset_n = 1'b0;
    #2;
    check("reset_outputs", 32'({mem_req, stall, char_valid, int_valid, halt, bad_code,
                                str_trunc}), 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Aligned "Hi": chars on cycles 3 and 5, three requests to 0x100, DONE on cycle 8.
    run_str(32'h100, 0);
    check_str("str_hi", "Hi", 0, 3, 32'h100, 8);
    check("str_hi_at0", 32'(got_at[0]), 32'd3);
    check("str_hi_at1", 32'(got_at[1]), 32'd5);
    check("str_hi_addr0", hs_addr[0], 32'h100);

    // Unaligned start with 3 wait states per request.
    mem[8'h40] = 32'h1122_4142;
    run_str(32'h102, 3);
    check_str("str_unal", "AB", 0, 3, 32'h104, 17);
    check("str_unal_at0", 32'(got_at[0]), 32'd6);
    check("str_unal_addr1", hs_addr[1], 32'h100);

    // Three chars, below the limit: no truncation.
    run_str(32'h300, 0);
    check_str("str_xyz", "xyz", 0, 4, 32'h300, 10);

    // "ABCDEF" cut at MAX_STR_LEN=4.
    run_str(32'h200, 0);
    check_str("str_trunc", "ABCD", 1, 4, 32'h200, 10);

    // Exit: halt and stall persist despite further syscall pulses.
    @(negedge clk);
    syscall_control = 1'b1;
    v0 = 32'd10;
    a0 = '0;
    @(negedge clk);
    check("exit_halt", 32'(halt), 32'd1);
    check("exit_stall", 32'(stall), 32'd1);
    check("exit_strobes", 32'({int_valid, char_valid, bad_code}), 32'd0);
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      syscall_control = c[0];
      v0 = 32'd1;
      a0 = 32'd5;
      @(negedge clk);
      if (!halt || !stall) bad++;
      if (int_valid || char_valid || bad_code || str_trunc) bad++;
    end
    check("exit_persist", 32'(bad), 32'd0);
    syscall_control = 1'b0;
    reset_n = 1'b0;
    #1;
    check("exit_reset_clear", 32'({halt, stall}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset in STR_REQ with memory never ready.
    mem[8'h40] = 32'h4869_0000;
    mem_wait = 1000;
    @(negedge clk);
    syscall_control = 1'b1;
    v0 = 32'd4;
    a0 = 32'h100;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_req", 32'(mem_req), 32'd1);
    check("rst_mid_addr", mem_addr, 32'h100);
    syscall_control = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_mid_flags", 32'({mem_req, stall, char_valid, int_valid, halt, bad_code,
                                str_trunc}), 32'd0);
    check("rst_mid_mem_addr", mem_addr, 32'd0);
    check("rst_mid_data", int_data | 32'(char_data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    mem_wait = 0;
    run_vec(vecs[2]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
